updown_counter_p: RTL and testbench
===================================

# updown_counter_p

Parametrised up/down counter; successor to the fixed 4-bit `updown` block. Width, modulus and step size are configurable. Adds synchronous load, count enable and a terminal-count pulse, plus sticky overflow/underflow flags and optional saturation. Sits in datapath and timer logic wherever a loadable bidirectional count is needed.

## Interface
Parameters:
- `WIDTH`, 4: count width in bits, 2..32.
- `MAX_COUNT`, 2**WIDTH-1: highest count value. Counting is modulo MAX_COUNT+1. Must be ≥1 and ≤2**WIDTH-1.
- `STEP_W`, 2: width of `step`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: count enable.
- `load`, in, 1: synchronous load of `load_val`.
- `load_val`, in, WIDTH: value to load.
- `up`, in, 1: count up request.
- `down`, in, 1: count down request.
- `step`, in, STEP_W: increment/decrement magnitude.
- `sat`, in, 1: 1 = saturate at bounds, 0 = wrap. Only effective with `UDC_SAT_EN`.
- `clr_flags`, in, 1: clears `ovf` and `unf`.
- `count`, out, WIDTH: current count, registered.
- `tc`, out, 1: one-cycle terminal-count pulse, registered.
- `ovf`, out, 1: sticky up-wrap/up-saturation flag.
- `unf`, out, 1: sticky down-wrap/down-saturation flag.
- `zero`, out, 1: registered, high when the next-state count is 0.

## Operation
Priority, evaluated each rising edge of `clk`:
1. `load` (regardless of `en`): count ← min(`load_val`, MAX_COUNT). `tc` = 0. Flags untouched by the load.
2. `en` = 1 with exactly one of `up`/`down` high and `step` ≠ 0: perform the count (below).
3. Otherwise (including `up` = `down` = 1, or `step` = 0): hold. `tc` = 0.

Arithmetic:
- Computed at WIDTH+STEP_W+1 bits; no intermediate truncation.
- `step` > MAX_COUNT+1 is reduced modulo MAX_COUNT+1 before use.
- Up, wrap mode: s = count+step. If s > MAX_COUNT, count ← s-(MAX_COUNT+1), `tc` = 1, `ovf` set.
- Down, wrap mode: if step > count, count ← count+(MAX_COUNT+1)-step, `tc` = 1, `unf` set.
- Otherwise the count is simply updated and `tc` = 0.
- Saturate mode (`UDC_SAT_EN` defined and `sat` = 1): up clamps to MAX_COUNT and down clamps to 0 whenever the result would cross the bound. `tc`/`ovf`/`unf` fire as in wrap mode.
- A step that lands exactly on MAX_COUNT or 0 without crossing is not an event.
- Holding at a bound while further requests arrive re-pulses `tc` on each such request.

Flags:
- `ovf`/`unf` stay set until `clr_flags`.
- If a set and `clr_flags` occur in the same cycle, set wins.

## Timing
- All outputs are registered.
- `count`, `tc`, `zero` and the flags reflect an input sampled at edge N immediately after edge N. Latency is 1 cycle; no combinational input-to-output path.
- Reset (`rst_n` low, asynchronous, any time including mid-count): `count` = 0, `tc` = 0, `ovf` = 0, `unf` = 0, `zero` = 1.
- Reset release is synchronous to the first rising edge after `rst_n` goes high. Inputs are ignored while `rst_n` is low.
- `tc` is high for exactly one cycle per event. Back-to-back events give back-to-back pulses.

## Configuration
- `UDC_SAT_EN` defined: saturation logic is compiled in, and `sat` selects saturate (1) or wrap (0) per cycle.
- `UDC_SAT_EN` undefined: no saturation logic. `sat` stays in the port list but is ignored, and counting always wraps.

## Test plan
- Reset and load: WIDTH=4, MAX_COUNT=9. Assert `rst_n`=0 mid-count → `count`=0, `zero`=1, flags 0. Then `load`=1, `load_val`=5 → `count`=5. Then `load_val`=15 → `count`=9 (clamped).
- Up-wrap: `count`=8, up, `step`=3 → `count`=1, `tc` pulses for 1 cycle, `ovf`=1. Then `clr_flags` → `ovf`=0.
- Down-wrap: `count`=1, down, `step`=2 → `count`=9, `tc`=1, `unf`=1. Same cycle as `clr_flags`=1 → `unf` still 1.
- Hold conditions:
  - `up`=`down`=1 → hold.
  - `step`=0 → hold.
  - `en`=0 → hold.
  - `load` with `en`=0 → loads.
  - `load` with `up` → load wins.
- Saturation (`UDC_SAT_EN`, `sat`=1): `count`=8, up, `step`=3 → `count`=9, `tc`=1, `ovf`=1. Repeat → `count` stays 9 and `tc` pulses again. Down from 1 with `step`=3 → `count`=0, `unf`=1.
- Full-range wrap: WIDTH=8, MAX_COUNT=255, `step`=1, 256 up steps from 0 → `count` returns to 0 with exactly one `tc` pulse.

Source files
------------

// File: rtl/updown_counter_p.sv
// -----------------------------------------------------------------------------
// updown_counter_p
//
// Parametrised loadable up/down counter with modulus MAX_COUNT+1, variable
// step, count enable, one-cycle terminal-count pulse, sticky overflow and
// underflow flags, and optional saturation.
//
// Optional feature macro: UDC_SAT_EN
//   defined   : saturation logic is present; 'sat' selects saturate (1) or
//               wrap (0) on every cycle.
//   undefined : counting always wraps and 'sat' is ignored.
//
// Parameters
//   WIDTH     : count width in bits (2..32)
//   MAX_COUNT : highest count value, 1 .. 2**WIDTH-1
//   STEP_W    : width of 'step'
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : count enable
//   load      : synchronous load of load_val (clamped to MAX_COUNT), wins over counting
//   load_val  : value to load
//   up/down   : direction request; exactly one must be high to count
//   step      : count magnitude; 0 means hold
//   sat       : saturate (1) / wrap (0), only with UDC_SAT_EN
//   clr_flags : clears ovf/unf; a simultaneous set wins
//   count     : registered count
//   tc        : registered one-cycle terminal-count pulse
//   ovf/unf   : sticky up/down crossing flags
//   zero      : registered, high when count is 0
// -----------------------------------------------------------------------------
module updown_counter_p #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned STEP_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              zero
);

    // Arithmetic width: wide enough for count + step and for MAX_COUNT+1
    // even when WIDTH = 32.
    localparam int unsigned AW = WIDTH + STEP_W + 1;
    localparam logic [AW-1:0] MAX_A = AW'(MAX_COUNT);
    localparam logic [AW-1:0] MOD_A = MAX_A + AW'(1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             zero_q, zero_d;

    logic             sat_mode;
    logic [AW-1:0]    count_a;
    logic [AW-1:0]    step_a;
    logic [AW-1:0]    step_r;
    logic [AW-1:0]    sum_a;
    logic             ovf_set;
    logic             unf_set;

`ifdef UDC_SAT_EN
    assign sat_mode = sat;
`else
    logic sat_unused;
    assign sat_unused = sat;
    assign sat_mode   = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        count_a = AW'(count_q);
        step_a  = AW'(step);
        // A step equal to the modulus is kept as-is: it wraps a full turn
        // and still counts as a crossing.
        step_r  = (step_a > MOD_A) ? (step_a % MOD_A) : step_a;
        sum_a   = count_a + step_r;

        if (load) begin
            count_d = (AW'(load_val) > MAX_A) ? MAX_W : load_val;
        end else if (en && (up ^ down) && (step != '0)) begin
            if (up) begin
                if (sum_a > MAX_A) begin
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                    count_d = sat_mode ? MAX_W : WIDTH'(sum_a - MOD_A);
                end else begin
                    count_d = WIDTH'(sum_a);
                end
            end else begin
                if (step_r > count_a) begin
                    tc_d    = 1'b1;
                    unf_set = 1'b1;
                    count_d = sat_mode ? '0 : WIDTH'(count_a + MOD_A - step_r);
                end else begin
                    count_d = WIDTH'(count_a - step_r);
                end
            end
        end

        ovf_d  = ovf_set | (ovf_q & ~clr_flags);
        unf_d  = unf_set | (unf_q & ~clr_flags);
        zero_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_updown_counter_p.sv
module tb_updown_counter_p;

    localparam int unsigned MAXC = 9;
`ifdef UDC_SAT_EN
    localparam bit SAT_BUILT = 1'b1;
`else
    localparam bit SAT_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en, load, up, down, sat, clr_flags;
    logic [3:0] load_val;
    logic [1:0] step;
    logic [3:0] count;
    logic       tc, ovf, unf, zero;

    logic       en2, load2, up2, down2, sat2, clr2;
    logic [7:0] load_val2;
    logic [1:0] step2;
    logic [7:0] count2;
    logic       tc2, ovf2, unf2, zero2;

    int vectors = 0;
    int miscompares = 0;

    updown_counter_p #(.WIDTH(4), .MAX_COUNT(9), .STEP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .up(up), .down(down), .step(step), .sat(sat), .clr_flags(clr_flags),
        .count(count), .tc(tc), .ovf(ovf), .unf(unf), .zero(zero)
    );

    updown_counter_p #(.WIDTH(8), .MAX_COUNT(255), .STEP_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .load(load2), .load_val(load_val2),
        .up(up2), .down(down2), .step(step2), .sat(sat2), .clr_flags(clr2),
        .count(count2), .tc(tc2), .ovf(ovf2), .unf(unf2), .zero(zero2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the 4-bit / modulus-10 instance, straight from
    // the counting rules using plain integer arithmetic.
    typedef struct packed {
        longint cnt;
        logic   tc;
        logic   ovf;
        logic   unf;
        logic   zero;
    } mstate_t;

    function automatic mstate_t model_next(input mstate_t s, input bit ld, input longint lv,
                                           input bit e, input bit u, input bit d,
                                           input longint st, input bit sa, input bit clr);
        mstate_t n;
        longint  m;
        longint  k;
        bit      ov;
        bit      un;
        n  = s;
        m  = MAXC + 1;
        ov = 0;
        un = 0;
        n.tc = 0;
        if (ld) begin
            n.cnt = (lv > MAXC) ? MAXC : lv;
        end else if (e && (u != d) && st != 0) begin
            k = (st > m) ? st % m : st;
            if (u) begin
                if (s.cnt + k > MAXC) begin
                    n.tc = 1; ov = 1;
                    n.cnt = (sa && SAT_BUILT) ? MAXC : s.cnt + k - m;
                end else n.cnt = s.cnt + k;
            end else begin
                if (k > s.cnt) begin
                    n.tc = 1; un = 1;
                    n.cnt = (sa && SAT_BUILT) ? 0 : s.cnt + m - k;
                end else n.cnt = s.cnt - k;
            end
        end
        n.ovf  = ov || (s.ovf && !clr);
        n.unf  = un || (s.unf && !clr);
        n.zero = (n.cnt == 0);
        return n;
    endfunction

    mstate_t mdl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdl <= '{cnt: 0, tc: 0, ovf: 0, unf: 0, zero: 1};
        else
            mdl <= model_next(mdl, load, longint'(load_val), en, up, down,
                              longint'(step), sat, clr_flags);
    end

    always @(posedge clk) begin
        #1;
        check("cmp_count", count, mdl.cnt);
        check("cmp_tc",    tc,    mdl.tc);
        check("cmp_ovf",   ovf,   mdl.ovf);
        check("cmp_unf",   unf,   mdl.unf);
        check("cmp_zero",  zero,  mdl.zero);
    end

    task automatic drive(input bit ld, input int lv, input bit e, input bit u, input bit d,
                         input int st, input bit sa, input bit clr);
        load      = ld;
        load_val  = 4'(lv);
        en        = e;
        up        = u;
        down      = d;
        step      = 2'(st);
        sat       = sa;
        clr_flags = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ntc;
        rst_n = 1'b0;
        load = 0; load_val = '0; en = 0; up = 0; down = 0; step = '0; sat = 0; clr_flags = 0;
        load2 = 0; load_val2 = '0; en2 = 0; up2 = 0; down2 = 0; step2 = '0; sat2 = 0; clr2 = 0;
        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_zero",  zero,  1);
        rst_n = 1'b1;

        // Count a little, set ovf, then reset asynchronously mid-cycle.
        drive(1, 8, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 3, 0, 0);
        check("pre_rst_ovf", ovf, 1);
        drive(0, 0, 1, 1, 0, 1, 0, 0);
        check("pre_rst_count", count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_zero",  zero,  1);
        check("async_rst_ovf",   ovf,   0);
        check("async_rst_tc",    tc,    0);
        load = 0; en = 0; up = 0; step = '0;
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 5, 0, 0, 0, 0, 0, 0);  check("load5", count, 5);
        drive(1, 15, 0, 0, 0, 0, 0, 0); check("load15_clamp", count, 9);

        drive(1, 8, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 3, 0, 0);
        check("upwrap_count", count, 1); check("upwrap_tc", tc, 1); check("upwrap_ovf", ovf, 1);
        idle();
        check("upwrap_tc_drop", tc, 0); check("ovf_sticky", ovf, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("ovf_clr", ovf, 0);

        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 2, 0, 1);
        check("dnwrap_count", count, 9); check("dnwrap_tc", tc, 1); check("unf_set_wins", unf, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("unf_clr", unf, 0); check("dnwrap_tc_drop", tc, 0);

        drive(0, 0, 1, 1, 1, 1, 0, 0);  check("hold_updown", count, 9);
        drive(0, 0, 1, 1, 0, 0, 0, 0);  check("hold_step0", count, 9);
        drive(0, 0, 0, 1, 0, 1, 0, 0);  check("hold_en0", count, 9);
        drive(1, 4, 0, 0, 0, 0, 0, 0);  check("load_en0", count, 4);
        drive(1, 2, 1, 1, 0, 1, 0, 0);  check("load_wins", count, 2); check("load_tc", tc, 0);

        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 1, 0, 0);
        check("land0_count", count, 0); check("land0_zero", zero, 1);
        check("land0_tc", tc, 0); check("land0_unf", unf, 0);
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 2, 0, 0);
        check("landmax_count", count, 9); check("landmax_tc", tc, 0); check("landmax_ovf", ovf, 0);

        drive(0, 0, 1, 1, 0, 1, 0, 0);
        check("b2b_up_count", count, 0); check("b2b_up_tc", tc, 1);
        drive(0, 0, 1, 0, 1, 1, 0, 0);
        check("b2b_dn_count", count, 9); check("b2b_dn_tc", tc, 1);
        check("b2b_ovf", ovf, 1); check("b2b_unf", unf, 1);

        drive(1, 8, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 3, 1, 0);
        check("sat_up_count", count, SAT_BUILT ? 9 : 1);
        check("sat_up_tc", tc, 1); check("sat_up_ovf", ovf, 1);
        drive(0, 0, 1, 1, 0, 3, 1, 0);
        check("sat_rep_count", count, SAT_BUILT ? 9 : 4);
        check("sat_rep_tc", tc, SAT_BUILT ? 1 : 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 3, 1, 0);
        check("sat_dn_count", count, SAT_BUILT ? 0 : 8);
        check("sat_dn_unf", unf, 1); check("sat_dn_tc", tc, 1);
        idle();

        // Full-range wrap on the 8-bit instance.
        check("full_start", count2, 0);
        ntc = 0;
        en2 = 1; up2 = 1; step2 = 2'd1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            check("full_step", count2, (i + 1) % 256);
            if (tc2) ntc++;
        end
        en2 = 0; up2 = 0;
        @(negedge clk);
        check("full_end", count2, 0);
        check("full_tc_pulses", ntc, 1);
        check("full_ovf", ovf2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
